// File: rtl/l1_thresh_servo_sequencer.sv
// Threshold servo: per scaler period, steps each channel's threshold toward the target band.
// No-change pass takes 2*NCHAN+1 cycles; wr/upd requests stay held until thresh_ack_i.
module l1_thresh_servo_sequencer #(
  parameter int                  NCHAN       = 48,
  parameter int                  THRESH_W    = 18,
  parameter int                  STEP        = 16,
  parameter int                  MIN_THRESH  = 0,
  parameter logic [THRESH_W-1:0] INIT_THRESH = THRESH_W'(4000)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                enable_i,
  input  logic                trig_count_done_i,
  input  logic [31:0]         target_rate_i,
  input  logic [15:0]         target_delta_i,
  output logic [5:0]          scal_idx_o,
  input  logic [31:0]         scal_dat_i,
  input  logic                host_wr_i,
  input  logic [5:0]          host_idx_i,
  input  logic [THRESH_W-1:0] host_dat_i,
  output logic [5:0]          thresh_idx_o,
  output logic [THRESH_W-1:0] thresh_dat_o,
  output logic                thresh_wr_o,
  output logic                thresh_upd_o,
  input  logic                thresh_ack_i,
  output logic                busy_o,
  output logic                pass_done_o,
  output logic                overrun_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_READ   = 3'd2,
    S_CALC   = 3'd3,
    S_WRITE  = 3'd4,
    S_UPDATE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [5:0]        LAST_CH = 6'(NCHAN - 1);
  localparam logic [6:0]        NCHAN_L = 7'(NCHAN);
  localparam logic [THRESH_W:0] STEP_L  = (THRESH_W + 1)'(STEP);
  localparam logic [THRESH_W:0] MIN_L   = (THRESH_W + 1)'(MIN_THRESH);
  localparam logic [THRESH_W:0] MAX_L   = {1'b0, {THRESH_W{1'b1}}};

  state_t              state_q, state_d;
  logic [5:0]          ch_q, ch_d;
  logic                any_chg_q, any_chg_d;
  logic                overrun_q, overrun_d;
  logic [THRESH_W-1:0] shadow_q [NCHAN];

  logic                shadow_we;
  logic [5:0]          shadow_widx;
  logic [THRESH_W-1:0] shadow_wdat;
  logic                advance;
  logic                busy;

  logic [THRESH_W-1:0] cur_thr, new_thr, up_thr, dn_thr;
  logic [THRESH_W:0]   up_sum;
  logic [32:0]         hi_lim;
  logic [31:0]         lo_lim;

  assign cur_thr = shadow_q[ch_q];

  // Band limits are computed one bit wider / floored so extreme targets never wrap.
  assign hi_lim = {1'b0, target_rate_i} + {17'b0, target_delta_i};
  assign lo_lim = (target_rate_i > {16'b0, target_delta_i}) ?
                  (target_rate_i - {16'b0, target_delta_i}) : 32'd0;

  assign up_sum = {1'b0, cur_thr} + STEP_L;
  assign up_thr = (up_sum > MAX_L) ? MAX_L[THRESH_W-1:0] : up_sum[THRESH_W-1:0];
  assign dn_thr = ({1'b0, cur_thr} < (MIN_L + STEP_L)) ? MIN_L[THRESH_W-1:0] :
                  (cur_thr - STEP_L[THRESH_W-1:0]);

  always_comb begin
    new_thr = cur_thr;
    if ({1'b0, scal_dat_i} > hi_lim) begin
      new_thr = up_thr;
    end else if (scal_dat_i < lo_lim) begin
      new_thr = dn_thr;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_WAIT);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    any_chg_d   = any_chg_q;
    overrun_d   = overrun_q;
    shadow_we   = 1'b0;
    shadow_widx = ch_q;
    shadow_wdat = new_thr;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host_wr_i && ({1'b0, host_idx_i} < NCHAN_L)) begin
          shadow_we   = 1'b1;
          shadow_widx = host_idx_i;
          shadow_wdat = host_dat_i;
        end
        if (enable_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (trig_count_done_i) begin
          state_d   = S_READ;
          ch_d      = 6'd0;
          any_chg_d = 1'b0;
        end
      end
      S_READ: state_d = S_CALC;
      S_CALC: begin
        if (new_thr != cur_thr) begin
          shadow_we = 1'b1;
          any_chg_d = 1'b1;
          state_d   = S_WRITE;
        end else begin
          advance = 1'b1;
        end
      end
      S_WRITE:  if (thresh_ack_i) advance = 1'b1;
      S_UPDATE: if (thresh_ack_i) state_d = S_DONE;
      S_DONE:   state_d = enable_i ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (advance) begin
      if (ch_q == LAST_CH) begin
        state_d = any_chg_q ? S_UPDATE : S_DONE;
      end else begin
        ch_d    = ch_q + 6'd1;
        state_d = S_READ;
      end
    end

    if (busy && trig_count_done_i) overrun_d = 1'b1;
    if (state_d == S_IDLE) overrun_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      ch_q      <= 6'd0;
      any_chg_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      any_chg_q <= any_chg_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < NCHAN; i++) shadow_q[i] <= INIT_THRESH;
    end else if (shadow_we) begin
      shadow_q[shadow_widx] <= shadow_wdat;
    end
  end

  // The shadow entry already holds the new value while in WRITE.
  assign thresh_wr_o  = (state_q == S_WRITE);
  assign thresh_upd_o = (state_q == S_UPDATE);
  assign thresh_idx_o = thresh_wr_o ? ch_q : 6'd0;
  assign thresh_dat_o = thresh_wr_o ? cur_thr : '0;
  assign scal_idx_o   = ch_q;
  assign busy_o       = busy;
  assign pass_done_o  = (state_q == S_DONE);
  assign overrun_o    = overrun_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_l1_thresh_servo_sequencer.sv
// Bench for l1_thresh_servo_sequencer: directed scenarios plus randomized passes,
// checked against a per-pass list of expected writes computed from the servo rules.
module tb_l1_thresh_servo_sequencer;

  localparam int  NCH  = 48;
  localparam int  STEP = 16;
  localparam int  MINT = 0;
  localparam longint TMAX = 262143;

  logic        clk = 1'b0;
  logic        rst_n, enable, trig, host_wr;
  logic [31:0] rate, scal_dat;
  logic [15:0] delta;
  logic [5:0]  scal_idx, host_idx, t_idx;
  logic [17:0] host_dat, t_dat;
  logic        t_wr, t_upd, ack = 1'b0, busy, pdone, ovr;
  logic [2:0]  st;

  l1_thresh_servo_sequencer dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(enable), .trig_count_done_i(trig),
    .target_rate_i(rate), .target_delta_i(delta), .scal_idx_o(scal_idx), .scal_dat_i(scal_dat),
    .host_wr_i(host_wr), .host_idx_i(host_idx), .host_dat_i(host_dat),
    .thresh_idx_o(t_idx), .thresh_dat_o(t_dat), .thresh_wr_o(t_wr), .thresh_upd_o(t_upd),
    .thresh_ack_i(ack), .busy_o(busy), .pass_done_o(pdone), .overrun_o(ovr), .state_o(st)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  longint      shadow_m [NCH];
  logic [31:0] scal_mem [NCH];
  int          q_idx[$], log_idx[$];
  longint      q_dat[$], log_dat[$];
  bit          exp_upd = 0, pass_active = 0;
  int          exp_done_cyc = -1, trig_cyc = 0, last_done_cyc = 0;
  int          done_cnt = 0, wr_cnt = 0, upd_cnt = 0, hold_max = 0, ack_delay = 0;

  function automatic longint model_new(longint sh, longint s);
    longint hi, lo;
    hi = longint'(rate) + longint'(delta);
    lo = longint'(rate) - longint'(delta);
    if (lo < 0) lo = 0;
    if (s > hi) return (sh + STEP > TMAX) ? TMAX : sh + STEP;
    if (s < lo) return (sh - STEP < MINT) ? MINT : sh - STEP;
    return sh;
  endfunction

  task automatic model_arm();
    longint nv;
    bit any = 0;
    q_idx.delete(); q_dat.delete(); log_idx.delete(); log_dat.delete();
    for (int c = 0; c < NCH; c++) begin
      nv = model_new(shadow_m[c], longint'(scal_mem[c]));
      if (nv != shadow_m[c]) begin
        q_idx.push_back(c); q_dat.push_back(nv);
        log_idx.push_back(c); log_dat.push_back(nv);
        shadow_m[c] = nv;
        any = 1;
      end
    end
    exp_upd      = any;
    exp_done_cyc = any ? -1 : cyc + 2 * NCH + 1;
    trig_cyc     = cyc;
    pass_active  = 1;
    hold_max     = 0;
  endtask

  // Scaler RAM: data follows the index with one cycle of latency.
  initial forever begin
    @(negedge clk);
    scal_dat = (scal_idx < 6'(NCH)) ? scal_mem[scal_idx] : 32'd0;
  end

  // Ack responder: acknowledges each request after ack_delay cycles.
  int ack_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ack = 1'b0; ack_cnt = 0;
    end else if (ack) begin
      ack = 1'b0; ack_cnt = 0;
    end else if (t_wr || t_upd) begin
      if (ack_cnt >= ack_delay) ack = 1'b1;
      else ack_cnt++;
    end else begin
      ack_cnt = 0;
    end
  end

  // Compare process
  bit          wr_prev = 0, upd_prev = 0;
  logic [5:0]  h_idx;
  logic [17:0] h_dat;
  int          hold = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      wr_prev = 0; upd_prev = 0;
    end else begin
      if (t_wr || t_upd) chk("wr_upd_exclusive", t_wr && t_upd, 0);
      if (t_wr) begin
        if (!wr_prev) begin
          wr_cnt++;
          chk("wr_expected", pass_active && (q_idx.size() > 0), 1);
          if (q_idx.size() > 0) begin
            chk("wr_idx", t_idx, q_idx.pop_front());
            chk("wr_dat", t_dat, q_dat.pop_front());
          end
          h_idx = t_idx; h_dat = t_dat; hold = 1;
        end else begin
          chk("wr_idx_stable", t_idx, h_idx);
          chk("wr_dat_stable", t_dat, h_dat);
          hold++;
        end
        if (hold > hold_max) hold_max = hold;
      end
      if (t_upd && !upd_prev) begin
        upd_cnt++;
        chk("upd_expected", exp_upd && (q_idx.size() == 0), 1);
        exp_upd = 0;
      end
      if (pdone) begin
        chk("done_expected", pass_active && !exp_upd && (q_idx.size() == 0), 1);
        if (exp_done_cyc >= 0) chk("done_latency", cyc, exp_done_cyc);
        pass_active   = 0;
        last_done_cyc = cyc;
        done_cnt++;
      end
      wr_prev = t_wr; upd_prev = t_upd;
    end
  end

  task automatic wait_state(input int s, input int budget, input string nm);
    for (int i = 0; i < budget && st !== 3'(s); i++) @(negedge clk);
    chk(nm, st, s);
  endtask

  task automatic host_write(input int idx, input int dat, input bit accepted);
    @(negedge clk);
    host_wr = 1; host_idx = 6'(idx); host_dat = 18'(dat);
    @(negedge clk);
    host_wr = 0;
    if (accepted && idx < NCH) shadow_m[idx] = dat;
  endtask

  task automatic run_pass(input bit drop_en, input bit extra_trig);
    int start;
    @(negedge clk);
    model_arm();
    start = done_cnt;
    trig = 1;
    @(negedge clk);
    trig = 0;
    if (extra_trig) begin
      repeat (20) @(negedge clk);
      trig = 1;
      @(negedge clk);
      trig = 0;
    end
    if (drop_en) begin
      repeat ($urandom_range(2, 80)) @(negedge clk);
      enable = 0;
    end
    for (int i = 0; i < 5000 && done_cnt == start; i++) @(negedge clk);
    chk("pass_finished", done_cnt - start, 1);
  endtask

  task automatic chk_log1(input string nm, input int idx, input longint dat);
    chk({nm, "_nwr"}, log_idx.size(), 1);
    if (log_idx.size() == 1) begin
      chk({nm, "_idx"}, log_idx[0], idx);
      chk({nm, "_dat"}, log_dat[0], dat);
    end
  endtask

  int w0, u0, d0;
  longint sv, hi, lo;

  initial begin
    rst_n = 1; enable = 0; trig = 0; rate = 1000; delta = 100;
    host_wr = 0; host_idx = 0; host_dat = 0;
    for (int c = 0; c < NCH; c++) begin scal_mem[c] = 1000; shadow_m[c] = 4000; end

    #2 rst_n = 0;
    #1;
    chk("rst_wr", t_wr, 0);       chk("rst_upd", t_upd, 0);
    chk("rst_idx", t_idx, 0);     chk("rst_dat", t_dat, 0);
    chk("rst_busy", busy, 0);     chk("rst_done", pdone, 0);
    chk("rst_ovr", ovr, 0);       chk("rst_state", st, 0);
    chk("rst_scal_idx", scal_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_after_rst", st, 0);
    enable = 1;
    wait_state(1, 5, "enter_wait");
    chk("busy_in_wait", busy, 0);

    // All scalers inside the band: no requests, fixed latency
    w0 = wr_cnt; u0 = upd_cnt;
    run_pass(0, 0);
    chk("t1_latency", last_done_cyc - trig_cyc, 97);
    chk("t1_nwr", wr_cnt - w0, 0);
    chk("t1_nupd", upd_cnt - u0, 0);

    // One channel high
    scal_mem[5] = 5000;
    w0 = wr_cnt; u0 = upd_cnt;
    run_pass(0, 0);
    chk_log1("t2", 5, 4016);
    chk("t2_nwr", wr_cnt - w0, 1);
    chk("t2_nupd", upd_cnt - u0, 1);
    scal_mem[5] = 1000;

    // Host preload in IDLE, ignored out of range and outside IDLE
    enable = 0;
    wait_state(0, 10, "t3_idle");
    host_write(7, 8, 1);
    host_write(3, 262140, 1);
    host_write(50, 5, 1);
    enable = 1;
    wait_state(1, 5, "t3_wait");
    host_write(10, 100, 0);
    scal_mem[7] = 0; scal_mem[3] = 5000; scal_mem[10] = 9000;
    run_pass(0, 0);
    chk("t3_nwr", log_idx.size(), 3);
    if (log_idx.size() == 3) begin
      chk("t3_idx0", log_idx[0], 3);  chk("t3_dat0", log_dat[0], 262143);
      chk("t3_idx1", log_idx[1], 7);  chk("t3_dat1", log_dat[1], 0);
      chk("t3_idx2", log_idx[2], 10); chk("t3_dat2", log_dat[2], 4016);
    end
    run_pass(0, 0);
    chk_log1("t3_repeat", 10, 4032);
    scal_mem[3] = 1000; scal_mem[7] = 1000; scal_mem[10] = 1000;

    // Slow ack plus a second trigger mid-pass
    ack_delay = 10;
    scal_mem[20] = 9999;
    run_pass(0, 1);
    chk("t4_hold_ge10", hold_max >= 10, 1);
    chk("t4_overrun", ovr, 1);
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    chk("t4_single_pass", done_cnt - d0, 0);
    chk("t4_state_wait", st, 1);
    scal_mem[20] = 1000;
    ack_delay = 0;
    enable = 0;
    wait_state(0, 10, "t4_idle");
    chk("t4_ovr_cleared", ovr, 0);

    // Enable drop and trigger in the same cycle: enable wins
    enable = 1;
    wait_state(1, 5, "t5_wait");
    @(negedge clk);
    enable = 0; trig = 1;
    @(negedge clk);
    trig = 0;
    d0 = done_cnt;
    chk("t5_state_idle", st, 0);
    repeat (120) @(negedge clk);
    chk("t5_no_pass", done_cnt - d0, 0);
    chk("t5_ovr", ovr, 0);

    // Randomized passes
    enable = 1;
    wait_state(1, 5, "rnd_wait");
    for (int it = 0; it < 8; it++) begin
      ack_delay = $urandom_range(0, 3);
      if (it == 0) begin
        rate = 32'hFFFF_FFF0; delta = 16'h0100;
        for (int c = 0; c < NCH; c++) scal_mem[c] = 32'hFFFF_FFFF;
      end else if (it == 1) begin
        rate = 50; delta = 100;
        for (int c = 0; c < NCH; c++) scal_mem[c] = $urandom_range(0, 400);
      end else begin
        rate = $urandom_range(200, 100000); delta = 16'($urandom_range(0, 2000));
        hi = longint'(rate) + longint'(delta);
        lo = longint'(rate) - longint'(delta);
        for (int c = 0; c < NCH; c++) begin
          case ($urandom_range(0, 7))
            0: sv = hi;
            1: sv = lo;
            2: sv = hi + 1;
            3: sv = lo - 1;
            default: sv = longint'(rate) + $urandom_range(0, 4 * delta + 20) - 2 * longint'(delta) - 10;
          endcase
          if (sv < 0) sv = 0;
          scal_mem[c] = 32'(sv);
        end
      end
      run_pass(it % 3 == 2, 0);
      if (it == 0) chk("rnd_wide_band_latency", last_done_cyc - trig_cyc, 97);
      if (it % 3 == 2) begin
        wait_state(0, 5, "rnd_drop_idle");
        for (int k = 0; k < 3; k++) begin
          case ($urandom_range(0, 3))
            0: host_write($urandom_range(0, 63), 0, 1);
            1: host_write($urandom_range(0, 63), 262143 - $urandom_range(0, 20), 1);
            2: host_write($urandom_range(0, 63), $urandom_range(0, 20), 1);
            default: host_write($urandom_range(0, 63), $urandom_range(0, 262143), 1);
          endcase
        end
        enable = 1;
        wait_state(1, 5, "rnd_rewait");
      end
    end

    // Asynchronous reset in the middle of a write
    rate = 1000; delta = 100;
    for (int c = 0; c < NCH; c++) scal_mem[c] = 1000;
    run_pass(0, 0);
    scal_mem[2] = 9000;
    ack_delay = 50;
    @(negedge clk);
    model_arm();
    trig = 1;
    @(negedge clk);
    trig = 0;
    for (int i = 0; i < 400 && !t_wr; i++) @(negedge clk);
    chk("rst_reached_write", t_wr, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_wr", t_wr, 0);    chk("arst_upd", t_upd, 0);
    chk("arst_idx", t_idx, 0);  chk("arst_dat", t_dat, 0);
    chk("arst_busy", busy, 0);  chk("arst_state", st, 0);
    pass_active = 0; exp_upd = 0;
    q_idx.delete(); q_dat.delete();
    for (int c = 0; c < NCH; c++) shadow_m[c] = 4000;
    @(negedge clk);
    rst_n = 1;
    #1 chk("state_after_arst", st, 0);
    ack_delay = 1;
    wait_state(1, 5, "arst_rewait");
    run_pass(0, 0);
    chk_log1("arst_shadow", 2, 4016);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_thresh_servo_sequencer.md
Name: l1_thresh_servo_sequencer

Overview:
- Closed-loop threshold servo for the L1 trigger threshold/scaler datapath.
- On each scaler-period completion it walks every channel, reads its scaler, and compares it with target_rate ± target_delta.
- It steps the channel's threshold up or down, writes changed thresholds through the thresh_wr/ack handshake, then commits them with one thresh_upd/ack handshake.
- It keeps a shadow copy of all thresholds, which the host may preload while the servo is idle.

Parameters:
NCHAN, 48, number of channels (≤64)
THRESH_W, 18, threshold width
STEP, 16, threshold increment/decrement per iteration
MIN_THRESH, 0, lower clamp for threshold
INIT_THRESH, 18'd4000, shadow value after reset

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  servo enable (level)
trig_count_done_i  in  1  single-cycle pulse: new scaler values valid
target_rate_i  in  32  target scaler count
target_delta_i  in  16  deadband half-width
scal_idx_o  out  6  scaler read index
scal_dat_i  in  32  scaler value; valid 1 cycle after scal_idx_o
host_wr_i  in  1  host shadow write strobe (accepted only in IDLE)
host_idx_i  in  6  host write channel
host_dat_i  in  18  host write value
thresh_idx_o  out  6  threshold write channel
thresh_dat_o  out  18  threshold write value
thresh_wr_o  out  1  threshold write request
thresh_upd_o  out  1  threshold commit request
thresh_ack_i  in  1  ack for wr or upd
busy_o  out  1  high when state ≠ IDLE/WAIT
pass_done_o  out  1  1-cycle pulse at end of each pass
overrun_o  out  1  sticky: trig_count_done_i seen while busy
state_o  out  3  current state encoding

Behaviour:
- Reset (async, immediate):
  - all outputs 0, state IDLE, overrun_o 0.
  - shadow[0..NCHAN-1] = INIT_THRESH.
  - any outstanding handshake is abandoned.
- States (encoding 0..6): IDLE, WAIT, READ, CALC, WRITE, UPDATE, DONE.
- IDLE:
  - host_wr_i writes shadow[host_idx_i] = host_dat_i; host_idx_i ≥ NCHAN is ignored.
  - enable_i=1 → WAIT.
  - host_wr_i outside IDLE is ignored.
- WAIT:
  - enable_i=0 → IDLE.
  - trig_count_done_i → READ; channel counter ch=0, any_chg=0.
- READ: scal_idx_o=ch → CALC (next cycle, scal_dat_i valid).
- CALC: hi = target_rate_i + target_delta_i (33-bit, no wrap); lo = target_rate_i − target_delta_i, clamped at 0.
  - scal_dat_i > hi: new = min(shadow+STEP, 2^THRESH_W−1).
  - scal_dat_i < lo: new = max(shadow−STEP, MIN_THRESH); saturate, never wrap.
  - otherwise new = shadow.
  - new ≠ shadow: shadow[ch]=new, any_chg=1, then WRITE.
  - new = shadow: advance (see below).
- WRITE:
  - thresh_wr_o=1, thresh_idx_o=ch, thresh_dat_o=new; all held stable until thresh_ack_i is sampled high.
  - On ack, thresh_wr_o drops the next cycle (minimum 1 low cycle between requests), then advance.
- Advance: ch=NCHAN−1 → UPDATE if any_chg, else DONE; otherwise ch+1 → READ.
- UPDATE: thresh_upd_o=1, held until thresh_ack_i is sampled; then → DONE. thresh_wr_o and thresh_upd_o are never both high.
- DONE: pass_done_o=1 for one cycle → WAIT if enable_i, else IDLE.
- enable_i falling mid-pass: the pass completes, including WRITE and UPDATE, and the FSM then goes to IDLE. A handshake is never aborted except by reset.
- trig_count_done_i in READ..DONE: ignored, sets overrun_o. overrun_o clears on entry to IDLE.
- trig_count_done_i in the same cycle as the enable_i 1→0 transition in WAIT: enable wins → IDLE.
- Pass latency with no changes: 2·NCHAN+1 cycles from trigger to pass_done_o.
- thresh_ack_i while no request is outstanding: ignored.

Test Plan:
- Reset, enable=1, target=1000, delta=100, all scalers=1000, pulse trig → no thresh_wr_o or thresh_upd_o; pass_done_o pulses 97 cycles after trig (NCHAN=48).
- Scaler ch5=5000, others=1000, shadow=4000 → exactly one write (idx 5, dat 4016), then one thresh_upd_o.
- Scaler ch7=0, shadow[7]=8 (host write in IDLE), MIN_THRESH=0 → write idx 7, dat 0.
- Shadow ch3=262140, scaler high → dat 262143. Repeat the pass → no write for ch3.
- Ack delayed 10 cycles in WRITE → wr, idx and dat stable for all 10 cycles. Second trig pulse mid-pass → overrun_o=1, exactly one pass runs.
- Assert wb_rst_n_i low during WRITE → all outputs 0 asynchronously. After release, shadow=4000 and state_o=IDLE.
